// File: rtl/cache_sdram_port_pkg.sv
// ============================================================================
// Module      : cache_sdram_port_pkg
// Description : Shared types and constants for the cache/SDRAM port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cache_sdram_port_pkg;

    localparam int BURST  = 4;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CMD  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_REPLAY  = 3'd3,
        ST_WR_CMD  = 3'd4,
        ST_WR_DONE = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cache_sdram_port_line_buffer.sv
// ============================================================================
// Module      : line_buffer
// Description : Line-fill word buffer with a self-incrementing write counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module line_buffer
    import cache_sdram_port_pkg::*;
#(
    parameter  int DEPTH = BURST,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [IDX_W-1:0]  count_o,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (we_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i && !clr_i) begin
            mem_q[cnt_q] <= wdata_i;
        end
    end

    assign count_o   = cnt_q;
    assign rd_data_o = mem_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/cache_sdram_port.sv
// ============================================================================
// Module      : cache_sdram_port
// Description : Arbitrates cache line fills and CPU write-through onto one
//               SDRAM controller command port; fills are buffered and replayed.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cache_sdram_port
    import cache_sdram_port_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BURST  = cache_sdram_port_pkg::BURST
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cache_req_i,
    input  logic [ADDR_W-1:0] cache_addr_i,
    output logic              cache_fill_o,
    output logic [WORD_W-1:0] cache_data_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              wr_uds_i,
    input  logic              wr_lds_i,
    output logic              wr_ack_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        mem_be_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic              mem_rvalid_i,
    input  logic [WORD_W-1:0] mem_rdata_i
);

    localparam int IDX_W = $clog2(BURST);

    state_e              state_q;
    logic                mem_req_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [1:0]          mem_be_q;
    logic [WORD_W-1:0]   mem_wdata_q;
    logic                wr_ack_q;
    logic                cache_fill_q;
    logic [WORD_W-1:0]   cache_data_q;
    logic [IDX_W-1:0]    rd_idx_q;

    logic                w_rd_phase;
    logic                w_buf_we;
    logic                w_last_word;
    logic [IDX_W-1:0]    w_buf_cnt;
    logic [WORD_W-1:0]   w_buf_rdata;

    // Read words are accepted from command issue onward, so data racing mem_ack is kept.
    assign w_rd_phase  = (state_q == ST_RD_CMD) || (state_q == ST_RD_DATA);
    assign w_buf_we    = mem_rvalid_i && w_rd_phase;
    assign w_last_word = w_buf_we && (w_buf_cnt == IDX_W'(BURST - 1));

    line_buffer #(
        .DEPTH     (BURST)
    ) u_line_buffer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_i     (state_q == ST_IDLE),
        .we_i      (w_buf_we),
        .wdata_i   (mem_rdata_i),
        .rd_idx_i  (rd_idx_q),
        .count_o   (w_buf_cnt),
        .rd_data_o (w_buf_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 2'b11;
            mem_wdata_q  <= '0;
            wr_ack_q     <= 1'b0;
            cache_fill_q <= 1'b0;
            cache_data_q <= '0;
            rd_idx_q     <= '0;
        end else begin
            wr_ack_q     <= 1'b0;
            cache_fill_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rd_idx_q <= '0;
                    // Writes win so a following fill always sees the written data.
                    if (wr_req_i) begin
                        if (wr_uds_i || wr_lds_i) begin
                            mem_req_q   <= 1'b1;
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= wr_addr_i;
                            mem_wdata_q <= wr_data_i;
                            mem_be_q    <= {wr_uds_i, wr_lds_i};
                            state_q     <= ST_WR_CMD;
                        end else begin
                            wr_ack_q <= 1'b1;
                            state_q  <= ST_WR_DONE;
                        end
                    end else if (cache_req_i) begin
                        mem_req_q  <= 1'b1;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= cache_addr_i & ~ADDR_W'(7);
                        mem_be_q   <= 2'b11;
                        state_q    <= ST_RD_CMD;
                    end
                end
                ST_WR_CMD: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        wr_ack_q  <= 1'b1;
                        state_q   <= ST_WR_DONE;
                    end
                end
                ST_WR_DONE: begin
                    if (!wr_req_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD_CMD, ST_RD_DATA: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                    end
                    if (w_last_word && (state_q == ST_RD_DATA || mem_ack_i)) begin
                        cache_fill_q <= 1'b1;
                        cache_data_q <= w_buf_rdata;
                        rd_idx_q     <= rd_idx_q + 1'b1;
                        state_q      <= ST_REPLAY;
                    end else if (state_q == ST_RD_CMD && mem_ack_i) begin
                        state_q <= ST_RD_DATA;
                    end
                end
                ST_REPLAY: begin
                    // Word 0 was launched on entry; remaining words stream one per cycle.
                    cache_data_q <= w_buf_rdata;
                    rd_idx_q     <= rd_idx_q + 1'b1;
                    if (rd_idx_q == IDX_W'(BURST - 1)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_wr_o     = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign wr_ack_o     = wr_ack_q;
    assign cache_fill_o = cache_fill_q;
    assign cache_data_o = cache_data_q;

endmodule

`default_nettype wire
